// File: rtl/slot_grant_counter_if.sv
// rtl/slot_grant_counter_if.sv - request/grant and slot timing signals of the slot grant counter
interface slot_grant_counter_if #(
    parameter int CNT_W  = 4,
    parameter int NUM_CH = 8,
    parameter int CH_W   = 3
);
    logic              en;
    logic              start;
    logic              mode_oneshot;
    logic [CNT_W-1:0]  slot_last;
    logic [NUM_CH-1:0] ch_req;
    logic [CNT_W-1:0]  cnt;
    logic [CH_W-1:0]   ch_sel;
    logic              gnt_done;
    logic              count_done;
    logic              busy;

    modport master (
        output en, start, mode_oneshot, slot_last, ch_req,
        input  cnt, ch_sel, gnt_done, count_done, busy
    );

    modport slave (
        input  en, start, mode_oneshot, slot_last, ch_req,
        output cnt, ch_sel, gnt_done, count_done, busy
    );
endinterface

// File: rtl/slot_grant_counter.sv
// rtl/slot_grant_counter.sv - round-robin time-slice grant timer over NUM_CH channels
module slot_grant_counter #(
    parameter int                CNT_W    = 4,
    parameter int                NUM_CH   = 8,
    parameter int                CH_W     = 3,
    parameter logic [CNT_W-1:0]  DEF_LAST = 4'd9
) (
    input  logic                 Clk,
    input  logic                 count_reset,
    slot_grant_counter_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] last_q, last_n;
    logic [CH_W-1:0]  ch_sel, ch_sel_n;
    logic [CH_W-1:0]  ptr, ptr_n;
    logic [CH_W-1:0]  ch_inc;

    // Search wraps at NUM_CH, so indices above NUM_CH-1 are never produced.
    function automatic logic [CH_W-1:0] next_req(input logic [CH_W-1:0] p,
                                                 input logic [NUM_CH-1:0] req);
        logic            found;
        logic [CH_W-1:0] r;
        int              idx;
        found = 1'b0;
        r     = p;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(p) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && req[idx]) begin
                found = 1'b1;
                r     = CH_W'(idx);
            end
        end
        return r;
    endfunction

    assign ch_inc = (ch_sel == CH_W'(NUM_CH - 1)) ? '0 : ch_sel + 1'b1;

    always_ff @(posedge Clk or posedge count_reset) begin
        if (count_reset) begin
            state  <= IDLE;
            cnt    <= '0;
            ch_sel <= '0;
            ptr    <= '0;
            last_q <= DEF_LAST;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            ch_sel <= ch_sel_n;
            ptr    <= ptr_n;
            last_q <= last_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ch_sel_n = ch_sel;
        ptr_n    = ptr;
        last_n   = last_q;
        case (state)
            IDLE: begin
                if (bus.start && (bus.ch_req != '0)) begin
                    state_n  = GRANT;
                    ch_sel_n = next_req(ptr, bus.ch_req);
                    cnt_n    = '0;
                    last_n   = bus.slot_last;
                end
            end
            GRANT: begin
                if (bus.en) begin
                    if (cnt != last_q) begin
                        cnt_n = cnt + 1'b1;
                    end else begin
                        // Slot end: the next slot starts on the following edge with no gap.
                        ptr_n = ch_inc;
                        cnt_n = '0;
                        if (bus.mode_oneshot || (bus.ch_req == '0)) begin
                            state_n = IDLE;
                        end else begin
                            ch_sel_n = next_req(ch_inc, bus.ch_req);
                            last_n   = bus.slot_last;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.cnt        = cnt;
    assign bus.ch_sel     = ch_sel;
    assign bus.busy       = (state == GRANT);
    assign bus.gnt_done   = (state == GRANT) && (cnt < last_q);
    assign bus.count_done = (state == GRANT) && (cnt == last_q);
endmodule

// File: tb/tb_slot_grant_counter.sv
// tb/tb_slot_grant_counter.sv - directed self-checking bench for slot_grant_counter
module tb_slot_grant_counter;
    logic Clk;
    logic count_reset;
    int   n_checks;
    int   n_errors;

    slot_grant_counter_if #(.CNT_W(4), .NUM_CH(8), .CH_W(3)) bus ();

    slot_grant_counter #(.CNT_W(4), .NUM_CH(8), .CH_W(3), .DEF_LAST(4'd9)) dut (
        .Clk         (Clk),
        .count_reset (count_reset),
        .bus         (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        count_reset = 1'b1;
        tick();
        count_reset = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        logic [2:0] rr_seq [5];
        n_checks = 0;
        n_errors = 0;
        count_reset      = 1'b1;
        bus.en           = 1'b1;
        bus.start        = 1'b0;
        bus.mode_oneshot = 1'b0;
        bus.slot_last    = 4'd9;
        bus.ch_req       = 8'h00;
        tick();
        tick();
        count_reset = 1'b0;

        check("rst_cnt",    32'(bus.cnt), 0);
        check("rst_ch_sel", 32'(bus.ch_sel), 0);
        check("rst_busy",   32'(bus.busy), 0);
        check("rst_gnt",    32'(bus.gnt_done), 0);
        check("rst_cdone",  32'(bus.count_done), 0);

        // Single channel, continuous, back-to-back slots
        bus.ch_req = 8'h01;
        bus.slot_last = 4'd9;
        do_start();
        for (int k = 0; k < 20; k++) begin
            check("single_cnt",   32'(bus.cnt), 32'(k % 10));
            check("single_gnt",   32'(bus.gnt_done), 32'((k % 10) < 9));
            check("single_cdone", 32'(bus.count_done), 32'((k % 10) == 9));
            check("single_ch",    32'(bus.ch_sel), 0);
            check("single_busy",  32'(bus.busy), 1);
            tick();
        end

        // Round-robin skip, then drop ch 2 during ch 0's second slot
        do_reset();
        rr_seq[0] = 3'd0; rr_seq[1] = 3'd2; rr_seq[2] = 3'd7; rr_seq[3] = 3'd0; rr_seq[4] = 3'd7;
        bus.ch_req = 8'b1000_0101;
        bus.slot_last = 4'd2;
        do_start();
        for (int k = 0; k < 13; k++) begin
            check("rr_ch",  32'(bus.ch_sel), 32'(rr_seq[k / 3]));
            check("rr_cnt", 32'(bus.cnt), 32'(k % 3));
            if (k == 9) bus.ch_req = 8'b1000_0001;
            tick();
        end

        // One-shot and pointer retention
        do_reset();
        bus.mode_oneshot = 1'b1;
        bus.ch_req = 8'hFF;
        bus.slot_last = 4'd3;
        do_start();
        for (int k = 0; k < 4; k++) begin
            check("os_ch",   32'(bus.ch_sel), 0);
            check("os_cnt",  32'(bus.cnt), 32'(k));
            check("os_busy", 32'(bus.busy), 1);
            tick();
        end
        check("os_idle_busy", 32'(bus.busy), 0);
        check("os_idle_cnt",  32'(bus.cnt), 0);
        tick();
        check("os_still_idle", 32'(bus.busy), 0);
        do_start();
        check("os_second_ch",   32'(bus.ch_sel), 1);
        check("os_second_busy", 32'(bus.busy), 1);

        // Enable freeze, then 1-cycle slots
        do_reset();
        bus.mode_oneshot = 1'b0;
        bus.ch_req = 8'hFF;
        bus.slot_last = 4'd9;
        do_start();
        for (int k = 0; k < 4; k++) tick();
        check("frz_pre_cnt", 32'(bus.cnt), 4);
        bus.en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("frz_cnt",  32'(bus.cnt), 4);
            check("frz_busy", 32'(bus.busy), 1);
        end
        bus.en = 1'b1;
        tick();
        check("frz_resume_cnt", 32'(bus.cnt), 5);
        bus.slot_last = 4'd0;
        for (int k = 0; k < 4; k++) tick();
        check("mid_change_cnt",   32'(bus.cnt), 9);
        check("mid_change_cdone", 32'(bus.count_done), 1);
        tick();
        for (int k = 0; k < 10; k++) begin
            check("s0_ch",    32'(bus.ch_sel), 32'((1 + k) % 8));
            check("s0_cdone", 32'(bus.count_done), 1);
            check("s0_gnt",   32'(bus.gnt_done), 0);
            check("s0_cnt",   32'(bus.cnt), 0);
            tick();
        end

        // Async reset mid-slot clears ptr
        do_reset();
        bus.slot_last = 4'd9;
        bus.ch_req = 8'hFF;
        do_start();
        for (int k = 0; k < 15; k++) tick();
        check("pre_rst_ch",  32'(bus.ch_sel), 1);
        check("pre_rst_cnt", 32'(bus.cnt), 5);
        #2;
        count_reset = 1'b1;
        #1;
        check("arst_cnt",   32'(bus.cnt), 0);
        check("arst_ch",    32'(bus.ch_sel), 0);
        check("arst_busy",  32'(bus.busy), 0);
        check("arst_gnt",   32'(bus.gnt_done), 0);
        check("arst_cdone", 32'(bus.count_done), 0);
        tick();
        count_reset = 1'b0;
        do_start();
        check("ptr_cleared_ch", 32'(bus.ch_sel), 0);
        check("ptr_cleared_busy", 32'(bus.busy), 1);

        // Start with no requests is dropped
        do_reset();
        bus.ch_req = 8'h00;
        do_start();
        check("empty_start_busy", 32'(bus.busy), 0);
        tick();
        check("empty_start_busy2", 32'(bus.busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/slot_grant_counter.md
Name: slot_grant_counter

Overview:
- Parametrised successor to the fixed mod-10 grant timer.
- Time-slices NUM_CH requesting channels round-robin. Each granted channel gets a slot of (slot_last+1) cycles.
- gnt_done is high for all but the final cycle of a slot; count_done flags the final cycle.
- Sits between the per-channel request logic and the shared datapath arbiter in the 8-channel design.

Parameters:
- CNT_W, 4: width of the in-slot cycle counter and slot_last.
- NUM_CH, 8: number of channels; any value 2..16.
- CH_W, 3: channel index width; must satisfy 2^CH_W >= NUM_CH.
- DEF_LAST, 9: reset value of the latched terminal count.

Ports:
- Clk  input  1  clock, rising edge.
- count_reset  input  1  reset, asynchronous, active-high.
- en  input  1  count enable; low freezes cnt and state in GRANT.
- start  input  1  begins a grant sequence from IDLE; ignored otherwise.
- mode_oneshot  input  1  1 = return to IDLE after one slot; 0 = continuous round-robin.
- slot_last  input  CNT_W  terminal count; sampled at every slot start.
- ch_req  input  NUM_CH  per-channel request, level.
- cnt  output  CNT_W  in-slot cycle count (registered).
- ch_sel  output  CH_W  currently granted channel (registered).
- gnt_done  output  1  GRANT && cnt < last_q.
- count_done  output  1  GRANT && cnt == last_q.
- busy  output  1  state == GRANT.

Behaviour:
- Reset (async, count_reset=1):
  - state=IDLE, cnt=0, ch_sel=0, ptr=0, last_q=DEF_LAST.
  - All 1-bit outputs are 0.
- gnt_done, count_done and busy are combinational decodes of registered state only; none depends on any input.
- next_req(p): first index i in p, p+1, ... NUM_CH-1, 0, ... p-1 with ch_req[i]=1. The search wraps at NUM_CH, not at 2^CH_W.
- IDLE:
  - If start=1 and |ch_req: on the next edge go to GRANT, ch_sel=next_req(ptr), cnt=0, last_q=slot_last.
  - start with ch_req=0 is dropped; state stays IDLE.
- GRANT, en=0: hold everything. count_done may stay high while frozen.
- GRANT, en=1, cnt<last_q: cnt<=cnt+1.
- GRANT, en=1, cnt==last_q (slot end): ptr<=(ch_sel+1) mod NUM_CH, then:
  - if mode_oneshot=1: go to IDLE, cnt=0, ch_sel holds.
  - else if no channel requesting: go to IDLE, cnt=0.
  - else: stay in GRANT, ch_sel=next_req((ch_sel+1) mod NUM_CH), cnt=0, last_q=slot_last. The next slot starts with no idle cycle between slots.
  - A channel that is the only requester is re-granted back-to-back.
- Requests dropping mid-slot do not shorten the slot. Requests are only sampled at slot start and slot end.
- slot_last=0 gives 1-cycle slots: count_done=1 and gnt_done=0 for the whole slot.
- slot_last=2^CNT_W-1 is legal. cnt never overflows because it resets at last_q.
- Changes to slot_last mid-slot have no effect until the next slot start.
- start during GRANT is ignored.
- count_reset mid-slot aborts immediately to the reset state, including ptr=0.
- Latency: start to busy=1 is 1 cycle. Slot length is (last_q+1) enabled cycles.

Test Plan:
1. Reset:
   - Stimulus: assert count_reset asynchronously mid-cycle.
   - Required: cnt=0, ch_sel=0, busy=0, gnt_done=0, count_done=0 before the next edge.
2. Single channel, continuous:
   - Stimulus: ch_req=8'h01, slot_last=9, mode_oneshot=0, en=1, pulse start.
   - Required: cnt runs 0..9; gnt_done high for 9 cycles then count_done high for 1; the pattern repeats with ch_sel=0 and no gap.
3. Round-robin skip:
   - Stimulus: ch_req=8'b1000_0101, slot_last=2.
   - Required: ch_sel sequence 0,2,7,0,... with 3 cycles each.
   - Then drop ch_req[2] during ch 0's slot. Required: next grant is 7.
4. One-shot and ptr retention:
   - Stimulus: mode_oneshot=1, ch_req=8'hFF, slot_last=3, start.
   - Required: ch 0 granted for 4 cycles, then IDLE.
   - Stimulus: second start. Required: ch_sel=1.
5. Enable freeze and boundary:
   - Stimulus: en=0 for 5 cycles at cnt=4. Required: cnt stays 4 and busy stays 1.
   - Stimulus: slot_last=0. Required: count_done=1 and gnt_done=0 every cycle while ch_sel advances each cycle.
6. Reset mid-slot and empty start:
   - Stimulus: count_reset at cnt=5. Required: IDLE, ptr=0.
   - Stimulus: start with ch_req=0. Required: busy stays 0.
